// File: rtl/apb_master_if.sv
// APB request bus plus four per-slave response channels shared between
// the apb_master and its slaves.
interface apb_master_if;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL0;
    logic        PSEL1;
    logic        PSEL2;
    logic        PSEL3;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic        PREADY0;
    logic        PREADY1;
    logic        PREADY2;
    logic        PREADY3;

    modport master (
        output PADDR, PWRITE, PENABLE, PWDATA,
        output PSEL0, PSEL1, PSEL2, PSEL3,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3
    );

    modport slave (
        input  PADDR, PWRITE, PENABLE, PWDATA,
        input  PSEL0, PSEL1, PSEL2, PSEL3,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master bridging a host request strobe to four decoded
// slaves, with a wait-state timeout and an immediate error path for unmapped addresses.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    input  logic         transfer,
    input  logic [31:0]  addr,
    input  logic         write,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         ready,
    output logic         error,
    apb_master_if.master apb
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StErr} state_e;

    // Abort fires on the edge ending the TIMEOUT-th low-PREADY ACCESS cycle.
    localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;

    logic        req_mapped;
    logic [1:0]  req_sel;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        bus_active;

    assign req_mapped = (addr[31:16] == 16'h1000) && (addr[15:14] == 2'b00);
    assign req_sel    = addr[13:12];

    // Only the selected slave's response is ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'h0;
        unique case (sel_q)
            2'd0: begin sel_ready = apb.PREADY0; sel_rdata = apb.PRDATA0; end
            2'd1: begin sel_ready = apb.PREADY1; sel_rdata = apb.PRDATA1; end
            2'd2: begin sel_ready = apb.PREADY2; sel_rdata = apb.PRDATA2; end
            2'd3: begin sel_ready = apb.PREADY3; sel_rdata = apb.PRDATA3; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        sel_d    = sel_q;
        wait_d   = wait_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        error_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    paddr_d  = addr;
                    pwrite_d = write;
                    pwdata_d = wdata;
                    sel_d    = req_sel;
                    state_d  = req_mapped ? StSetup : StErr;
                end
            end
            StSetup: begin
                wait_d  = 8'd0;
                state_d = StAccess;
            end
            StAccess: begin
                // A late PREADY on the final allowed cycle still wins.
                if (sel_ready) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    if (!pwrite_q) begin
                        rdata_d = sel_rdata;
                    end
                end else if (wait_q == LastWait) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StErr: begin
                state_d = StIdle;
                ready_d = 1'b1;
                error_d = 1'b1;
                rdata_d = 32'h0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q  <= StIdle;
            paddr_q  <= 32'h0;
            pwdata_q <= 32'h0;
            pwrite_q <= 1'b0;
            sel_q    <= 2'd0;
            wait_q   <= 8'd0;
            rdata_q  <= 32'h0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            sel_q    <= sel_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
        end
    end

    assign bus_active  = (state_q == StSetup) || (state_q == StAccess);

    assign apb.PSEL0   = bus_active && (sel_q == 2'd0);
    assign apb.PSEL1   = bus_active && (sel_q == 2'd1);
    assign apb.PSEL2   = bus_active && (sel_q == 2'd2);
    assign apb.PSEL3   = bus_active && (sel_q == 2'd3);
    assign apb.PENABLE = (state_q == StAccess);
    assign apb.PADDR   = paddr_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PWDATA  = pwdata_q;

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign error = error_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: slave models with programmable wait states, a scoreboard
// of expected completions, and a bus monitor checking selects and phase timing.
module tb_apb_master;

    localparam int unsigned TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        error;

    apb_master_if bus ();

    apb_master #(.TIMEOUT(TIMEOUT)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .addr     (addr),
        .write    (write),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .error    (error),
        .apb      (bus)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave models: selected slave waits wait_cfg ACCESS cycles; idle slaves drive bait.
    logic [3:0] psel_v;
    int         wait_cfg = 0;
    int         acc_cnt  = 0;
    logic [3:0] gpo;

    assign psel_v = {bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};

    function automatic logic [31:0] slave_val(input int i, input logic [31:0] a);
        return (i == 1) ? 32'h0000_00A5 : {16'hCAFE, a[15:0]};
    endfunction

    always @(posedge PCLK) begin
        if (bus.PENABLE && psel_v != 4'b0) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign bus.PREADY0 = psel_v[0] ? (bus.PENABLE && acc_cnt >= wait_cfg) : 1'b1;
    assign bus.PREADY1 = psel_v[1] ? (bus.PENABLE && acc_cnt >= wait_cfg) : 1'b1;
    assign bus.PREADY2 = psel_v[2] ? (bus.PENABLE && acc_cnt >= wait_cfg) : 1'b1;
    assign bus.PREADY3 = psel_v[3] ? (bus.PENABLE && acc_cnt >= wait_cfg) : 1'b1;
    assign bus.PRDATA0 = psel_v[0] ? slave_val(0, bus.PADDR) : 32'hBAD0_0000;
    assign bus.PRDATA1 = psel_v[1] ? slave_val(1, bus.PADDR) : 32'hBAD0_0001;
    assign bus.PRDATA2 = psel_v[2] ? slave_val(2, bus.PADDR) : 32'hBAD0_0002;
    assign bus.PRDATA3 = psel_v[3] ? slave_val(3, bus.PADDR) : 32'hBAD0_0003;

    always @(posedge PCLK) begin
        if (!PRESET) gpo <= 4'h0;
        else if (bus.PSEL0 && bus.PENABLE && bus.PREADY0 && bus.PWRITE) gpo <= bus.PWDATA[3:0];
    end

    // Scoreboard
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  psel;
        int          n_acc;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] rdata_model = 32'h0;

    function automatic logic [3:0] exp_psel(input logic [31:0] a);
        logic [3:0] one = 4'b0001;
        if (a[31:16] == 16'h1000 && a[15:12] < 4'd4) return one << a[13:12];
        return 4'b0000;
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic wr, input logic [31:0] d,
                            input logic [31:0] rd_val, input logic err, input int lat);
        exp_t e;
        e.addr  = a;
        e.wr    = wr;
        e.wdata = d;
        e.psel  = exp_psel(a);
        e.n_acc = (e.psel != 4'b0) ? lat - 2 : 0;
        e.err   = err;
        e.due   = cyc + lat;
        if (err) rdata_model = 32'h0;
        else if (!wr) rdata_model = rd_val;
        e.rdata = rdata_model;
        sb_q.push_back(e);
    endtask

    // Bus monitor and completion checker
    int          setup_obs = 0;
    int          acc_obs   = 0;
    logic [68:0] cap;

    always @(negedge PCLK) begin
        if (!PRESET) begin
            setup_obs = 0;
            acc_obs   = 0;
        end else begin
            chk("bus_legal", {70'b0, ($countones(psel_v) > 1), (bus.PENABLE && psel_v == 4'b0)}, 72'b0);
            if (psel_v != 4'b0 && !bus.PENABLE) begin
                setup_obs++;
                cap = {bus.PADDR, bus.PWRITE, bus.PWDATA, psel_v};
                chk("setup_pending", {71'b0, (sb_q.size() != 0)}, 72'b1);
                if (sb_q.size() != 0)
                    chk("setup_bus", {3'b0, cap},
                        {3'b0, sb_q[0].addr, sb_q[0].wr, sb_q[0].wdata, sb_q[0].psel});
            end
            if (psel_v != 4'b0 && bus.PENABLE) begin
                acc_obs++;
                chk("access_stable", {3'b0, bus.PADDR, bus.PWRITE, bus.PWDATA, psel_v}, {3'b0, cap});
            end
            if (ready) begin
                chk("ready_bus_idle", {67'b0, psel_v, bus.PENABLE}, 72'b0);
                chk("ready_pending", {71'b0, (sb_q.size() != 0)}, 72'b1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rdata", {40'b0, rdata}, {40'b0, e.rdata});
                    chk("error", {71'b0, error}, {71'b0, e.err});
                    chk("latency", 72'(cyc), 72'(e.due));
                    chk("access_cycles", 72'(acc_obs), 72'(e.n_acc));
                    chk("setup_cycles", 72'(setup_obs), (e.psel != 4'b0) ? 72'd1 : 72'd0);
                end
                setup_obs = 0;
                acc_obs   = 0;
            end
        end
    end

    task automatic wait_done(input string name);
        for (int k = 0; k < 40 && sb_q.size() != 0; k++) begin
            @(posedge PCLK);
            #1;
        end
        chk({name, "_done"}, 72'(sb_q.size()), 72'd0);
        sb_q.delete();
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [31:0] d);
        transfer = 1'b1;
        addr     = a;
        write    = wr;
        wdata    = d;
    endtask

    task automatic run_xfer(input logic [31:0] a, input logic wr, input logic [31:0] d,
                            input logic [31:0] rd_val, input logic err, input int lat);
        push_exp(a, wr, d, rd_val, err, lat);
        drive(a, wr, d);
        @(posedge PCLK);
        #1;
        transfer = 1'b0;
        wait_done("xfer");
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rd_val;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'h1000_0000, 1'b1, 32'h0000_000F, 0,  32'h0,         1'b0, 3};
        vecs[1]  = '{32'h1000_0004, 1'b1, 32'h0000_0005, 0,  32'h0,         1'b0, 3};
        vecs[2]  = '{32'h1000_1000, 1'b0, 32'h0,         3,  32'h0000_00A5, 1'b0, 6};
        vecs[3]  = '{32'h2000_0000, 1'b0, 32'h0,         0,  32'h0,         1'b1, 2};
        vecs[4]  = '{32'h1000_2004, 1'b1, 32'hDEAD_0001, 16, 32'h0,         1'b1, 18};
        vecs[5]  = '{32'h1000_3010, 1'b0, 32'h0,         0,  32'hCAFE_3010, 1'b0, 3};
        vecs[6]  = '{32'h1000_2008, 1'b0, 32'h0,         15, 32'hCAFE_2008, 1'b0, 18};
        vecs[7]  = '{32'h1000_3000, 1'b1, 32'h1234_5678, 1,  32'h0,         1'b0, 4};
        vecs[8]  = '{32'h1000_4000, 1'b0, 32'h0,         0,  32'h0,         1'b1, 2};
        vecs[9]  = '{32'h1001_0000, 1'b0, 32'h0,         0,  32'h0,         1'b1, 2};
        vecs[10] = '{32'h1000_0000, 1'b0, 32'h0,         2,  32'hCAFE_0000, 1'b0, 5};
        vecs[11] = '{32'h1000_1FFC, 1'b1, 32'h0000_0000, 0,  32'h0,         1'b0, 3};

        PRESET   = 1'b0;
        transfer = 1'b0;
        addr     = 32'h0;
        write    = 1'b0;
        wdata    = 32'h0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_rdata", {40'b0, rdata}, 72'b0);
        chk("rst_ready_error", {70'b0, ready, error}, 72'b0);
        chk("rst_bus_ctrl", {66'b0, psel_v, bus.PENABLE, bus.PWRITE}, 72'b0);
        chk("rst_paddr_pwdata", {8'b0, bus.PADDR, bus.PWDATA}, 72'b0);
        PRESET = 1'b1;

        for (int i = 0; i < 12; i++) begin
            wait_cfg = vecs[i].waits;
            run_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rd_val,
                     vecs[i].err, vecs[i].lat);
        end
        chk("gpo_out", {68'b0, gpo}, 72'h5);

        // Back-to-back: second request rides on the first ready cycle.
        wait_cfg = 0;
        push_exp(32'h1000_0008, 1'b1, 32'h0000_00AA, 32'h0, 1'b0, 3);
        drive(32'h1000_0008, 1'b1, 32'h0000_00AA);
        @(posedge PCLK);
        #1;
        transfer = 1'b0;
        for (int k = 0; k < 10 && !ready; k++) begin
            @(posedge PCLK);
            #1;
        end
        push_exp(32'h1000_300C, 1'b1, 32'h0000_0055, 32'h0, 1'b0, 3);
        drive(32'h1000_300C, 1'b1, 32'h0000_0055);
        @(posedge PCLK);
        #1;
        transfer = 1'b0;
        wait_done("b2b");

        // Reset mid-ACCESS of a wait-stated read abandons it silently.
        wait_cfg = 8;
        push_exp(32'h1000_1000, 1'b0, 32'h0, 32'h0000_00A5, 1'b0, 11);
        drive(32'h1000_1000, 1'b0, 32'h0);
        @(posedge PCLK);
        #1;
        transfer = 1'b0;
        for (int k = 0; k < 10 && !bus.PENABLE; k++) begin
            @(posedge PCLK);
            #1;
        end
        repeat (2) @(posedge PCLK);
        #1;
        chk("pre_reset_in_access", {71'b0, bus.PENABLE}, 72'b1);
        PRESET   = 1'b0;
        transfer = 1'b1;
        sb_q.delete();
        rdata_model = 32'h0;
        @(posedge PCLK);
        #1;
        chk("mid_rst_bus", {67'b0, psel_v, bus.PENABLE}, 72'b0);
        chk("mid_rst_host", {38'b0, rdata, ready, error}, 72'b0);
        chk("mid_rst_paddr", {40'b0, bus.PADDR}, 72'b0);
        @(posedge PCLK);
        #1;
        PRESET   = 1'b1;
        transfer = 1'b0;
        repeat (12) @(posedge PCLK);
        #1;
        wait_cfg = 0;
        run_xfer(32'h1000_1000, 1'b0, 32'h0, 32'h0000_00A5, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
